ahblite_uart_buf: RTL

AHBLITE_UART_BUF -- requirements
Module: ahblite_uart_buf

---
 rtl/ahblite_uart_pkg.sv | 32 +++
 rtl/uart_sync_fifo.sv | 71 +++++++
 rtl/ahblite_uart_buf.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ahblite_uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FIFO depth limit for the
// AHB-lite UART buffer.
package ahblite_uart_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_RSVD   = 4'hC;

    localparam int ST_RX_EMPTY    = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_OVERFLOW = 5;

    localparam int CTRL_RX_IRQ_EN  = 0;
    localparam int CTRL_TX_IRQ_EN  = 1;
    localparam int CTRL_ERR_IRQ_EN = 2;
    localparam int CTRL_RX_FLUSH   = 8;
    localparam int CTRL_TX_FLUSH   = 9;

    localparam int MAX_FIFO_DEPTH = 128;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with push/pop/flush; a push into a full FIFO is accepted
// only when a pop retires an entry on the same edge. Flush wins over both.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; validity is tracked by level/pointers.
    always_ff @(posedge HCLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ahblite_uart_buf.sv
// Zero-wait AHB-lite register front end with TX/RX character FIFOs for a UART.
// Define UART_BUF_IRQ_EN to build the CTRL interrupt enables and registered irq.
module ahblite_uart_buf
    import ahblite_uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [3:0]        HPROT,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              irq
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic        acc_valid_q, acc_valid_d;
    logic        acc_write_q, acc_write_d;
    reg_sel_e    acc_sel_q, acc_sel_d;
    logic        tx_overflow_q, tx_overflow_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic [2:0]  irq_en;

    logic              wr_phase, rd_phase, ctrl_wr, status_wr;
    logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic              rx_pop, rx_flush, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic [LW-1:0]     tx_level, rx_level;
    logic              unused_bits;

    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HSIZE, HPROT, HTRANS[0], HWDATA};

    assign wr_phase  = acc_valid_q & acc_write_q;
    assign rd_phase  = acc_valid_q & ~acc_write_q;
    assign ctrl_wr   = wr_phase & (acc_sel_q == REG_CTRL);
    assign status_wr = wr_phase & (acc_sel_q == REG_STATUS);
    assign tx_push   = wr_phase & (acc_sel_q == REG_DATA);
    assign rx_pop    = rd_phase & (acc_sel_q == REG_DATA) & ~rx_empty;
    assign tx_pop    = tx_valid & tx_ready;
    assign tx_valid  = ~tx_empty;
    assign tx_flush  = ctrl_wr & HWDATA[CTRL_TX_FLUSH];
    assign rx_flush  = ctrl_wr & HWDATA[CTRL_RX_FLUSH];

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .push(tx_push), .wdata(HWDATA[DATA_W-1:0]), .pop(tx_pop), .flush(tx_flush),
        .rdata(tx_data), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .push(rx_valid), .wdata(rx_data), .pop(rx_pop), .flush(rx_flush),
        .rdata(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    always_comb begin
        acc_valid_d = acc_valid_q;
        acc_write_d = acc_write_q;
        acc_sel_d   = acc_sel_q;
        if (HREADY) begin
            acc_valid_d = HSEL & HTRANS[1];
            acc_write_d = HWRITE;
            acc_sel_d   = reg_sel_e'(HADDR[3:2]);
        end

        // A new error event on the same edge as its clear takes precedence.
        tx_overflow_d = tx_overflow_q;
        if (status_wr && HWDATA[ST_TX_OVERFLOW]) tx_overflow_d = 1'b0;
        if (tx_push && tx_full && !tx_pop)       tx_overflow_d = 1'b1;

        rx_overrun_d = rx_overrun_q;
        if (status_wr && HWDATA[ST_RX_OVERRUN])  rx_overrun_d = 1'b0;
        if (rx_valid && rx_full && !rx_pop)      rx_overrun_d = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            acc_valid_q   <= 1'b0;
            acc_write_q   <= 1'b0;
            acc_sel_q     <= REG_DATA;
            tx_overflow_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            acc_valid_q   <= acc_valid_d;
            acc_write_q   <= acc_write_d;
            acc_sel_q     <= acc_sel_d;
            tx_overflow_q <= tx_overflow_d;
            rx_overrun_q  <= rx_overrun_d;
        end
    end

`ifdef UART_BUF_IRQ_EN
    logic [2:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;

    assign irq_en = ctrl_q;
    assign irq    = irq_q;

    always_comb begin
        ctrl_d = ctrl_wr ? HWDATA[2:0] : ctrl_q;
        irq_d  = (ctrl_q[CTRL_RX_IRQ_EN]  & ~rx_empty) |
                 (ctrl_q[CTRL_TX_IRQ_EN]  & tx_empty)  |
                 (ctrl_q[CTRL_ERR_IRQ_EN] & (rx_overrun_q | tx_overflow_q));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end
`else
    assign irq_en = 3'b000;
    assign irq    = 1'b0;
`endif

    always_comb begin
        HRDATA = '0;
        if (rd_phase) begin
            case (acc_sel_q)
                REG_DATA:   if (!rx_empty) HRDATA = 32'(rx_head);
                REG_STATUS: HRDATA = {8'h00, 8'(tx_level), 8'(rx_level), 2'b00,
                                      tx_overflow_q, rx_overrun_q,
                                      tx_full, tx_empty, rx_full, rx_empty};
                REG_CTRL:   HRDATA = {29'b0, irq_en};
                default:    HRDATA = '0;
            endcase
        end
    end

endmodule
